b13_serial_rx: RTL
==================

Name: b13_serial_rx

Overview:
Receiver for the b13 serial link: recovers 8-bit frames from the transmitter's data_out line and presents them on a valid/ack holding register.
- Line format: idle high; each slot is a single-cycle sample; slots are SLOT_PERIOD clocks apart.
- Frame: start slot 0, then bit7 first down to bit0, then stop slot 1.
- dsr is driven back to the transmitter as the ready indication.

Parameters:
SLOT_PERIOD, 106, clocks between consecutive slots (transmitter DelayTime+2); legal range 2..1023.
DATA_BITS, 8, data slots per frame; fixed at 8, not user-overridable.

Ports:
clock  input  1  rising-edge clock.
reset  input  1  asynchronous, active-high reset.
serial_in  input  1  serial line from the transmitter's data_out.
dsr  output  1  ready to accept a frame; equals !dato_valid.
dato  output  8  last good frame, bit7 = first data slot.
dato_valid  output  1  dato holds an unconsumed frame.
dato_ack  input  1  consumer takes dato; sampled only while dato_valid=1.
frame_error  output  1  one-cycle pulse on a bad stop slot.
overrun  output  1  present only with RX_OVERRUN_EN.

Behaviour:
- Reset, asynchronous: state R_IDLE; slot counter 0; bit index 0; shift register 0; dato 0; dato_valid 0; frame_error 0; overrun 0; dsr 1.
- Slot counter width: $clog2(SLOT_PERIOD) bits.
- Slot tick: asserted at any edge in R_DATA/R_STOP where counter == SLOT_PERIOD-1; counter then returns to 0, otherwise increments.
- R_IDLE, at each edge:
  - serial_in==0: start detected; counter←0, bit index←0 → R_DATA.
  - Otherwise stay in R_IDLE.
  - There is no glitch filter; any low sample starts a frame.
- R_DATA: on slot tick, shift ← {shift[6:0], serial_in} and index++. After the 8th data tick → R_STOP.
  - First data sample is at start edge + SLOT_PERIOD.
  - Data bit k is sampled at start edge + (k+1)*SLOT_PERIOD.
- R_STOP: on slot tick (start edge + 9*SLOT_PERIOD) → R_IDLE, with:
  - serial_in==1 and (dato_valid==0 or dato_ack==1): dato←shift, dato_valid←1.
  - serial_in==1, dato_valid==1, dato_ack==0: overrun case; see Optional Feature.
  - serial_in==0: frame_error=1 for exactly one cycle; frame discarded; dato/dato_valid unchanged.
- dato_ack with dato_valid=1 and no frame completing that edge: dato_valid←0; dato keeps its value.
- dato_ack while dato_valid=0: ignored.
- Stop-slot sampling edge is followed by R_IDLE; the next start is accepted from the following edge.
- serial_in is ignored between slot ticks.
- Reset mid-frame: partial frame is dropped and the block returns to the reset state immediately.
- Latency: dato_valid rises at the stop-slot edge; dsr falls with it (combinational inverse).

Optional Feature:
Macro RX_OVERRUN_EN.
- Defined: overrun port exists. In the overrun case, overrun pulses 1 for one cycle, dato keeps the old frame, and the new frame is lost.
- Undefined: no overrun port. In the overrun case, dato is overwritten with the new frame and dato_valid stays 1.

Decomposition:
- Package b13_rx_pkg: state enum (R_IDLE, R_DATA, R_STOP); SLOT_PERIOD_DEFAULT=106; DATA_BITS=8; START_LEVEL=0; STOP_LEVEL=1.
- Sub-module b13_slot_timer: owns the slot counter.
  - Inputs: clock, reset, clear, run.
  - Output: tick.
  - Reusable by a future matching transmitter rewrite.

Test Plan:
1. Reset, then frame 0xA5 (start low at edge E) → shift complete at E+8*106; dato=0xA5, dato_valid=1, dsr=0 at E+954; dato_ack one cycle later → dato_valid=0, dsr=1.
2. Frame 0x5A with stop slot driven 0 → frame_error high exactly at E+954 for 1 cycle; dato_valid stays 0; the next good frame 0x01 is received normally.
3. Frames 0x11 then 0x22 back-to-back, no ack:
   - With RX_OVERRUN_EN: overrun pulse at the second stop edge; dato=0x11.
   - Without RX_OVERRUN_EN: dato=0x22, dato_valid=1.
4. dato_ack asserted on the same edge as the second frame's stop slot → dato=0x22, dato_valid=1, no overrun.
5. Reset pulsed between data slots 3 and 4 of frame 0xFF → all outputs at reset values immediately; the following frame 0x3C yields dato=0x3C.
6. Line held high for 2000 cycles → state stays R_IDLE, dato_valid=0, frame_error=0. Frames 0x00 and 0xFF are received exactly.

Source files
------------

// File: rtl/b13_rx_pkg.sv
// b13 serial receiver: shared state encoding and line constants.
// Optional overrun reporting is enabled by defining RX_OVERRUN_EN.
package b13_rx_pkg;

  typedef enum logic [1:0] {
    R_IDLE,
    R_DATA,
    R_STOP
  } rx_state_e;

  localparam int   SLOT_PERIOD_DEFAULT = 106;
  localparam int   DATA_BITS           = 8;
  localparam logic START_LEVEL         = 1'b0;
  localparam logic STOP_LEVEL          = 1'b1;

endpackage

// File: rtl/b13_slot_timer.sv
// b13 slot timer: free-running slot counter, ticks every PERIOD clocks
// while run is high; clear forces it back to zero.
module b13_slot_timer
  import b13_rx_pkg::*;
#(
  parameter int PERIOD = SLOT_PERIOD_DEFAULT
) (
  input  logic clock,
  input  logic reset,
  input  logic clear,
  input  logic run,
  output logic tick
);

  localparam int W = (PERIOD > 1) ? $clog2(PERIOD) : 1;
  localparam logic [W-1:0] LAST = W'(PERIOD - 1);

  logic [W-1:0] cnt;

  assign tick = run && (cnt == LAST);

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      cnt <= '0;
    end else if (clear) begin
      cnt <= '0;
    end else if (run) begin
      cnt <= tick ? '0 : cnt + 1'b1;
    end
  end

endmodule

// File: rtl/b13_serial_rx.sv
// b13 serial receiver: start/8 data MSB-first/stop frames into a
// valid/ack holding register. Define RX_OVERRUN_EN for the overrun port.
module b13_serial_rx
  import b13_rx_pkg::*;
#(
  parameter int SLOT_PERIOD = SLOT_PERIOD_DEFAULT
) (
  input  logic       clock,
  input  logic       reset,
  input  logic       serial_in,
  output logic       dsr,
  output logic [7:0] dato,
  output logic       dato_valid,
  input  logic       dato_ack,
  output logic       frame_error
`ifdef RX_OVERRUN_EN
  ,
  output logic       overrun
`endif
);

  localparam logic [2:0] LAST_BIT = 3'(DATA_BITS - 1);

  rx_state_e state, state_n;
  logic [DATA_BITS-1:0] shift, shift_n;
  logic [2:0] idx, idx_n;
  logic [7:0] dato_n;
  logic valid_n, ferr_n;
  logic tick;
`ifdef RX_OVERRUN_EN
  logic ovr_n;
`endif

  b13_slot_timer #(
    .PERIOD(SLOT_PERIOD)
  ) u_timer (
    .clock(clock),
    .reset(reset),
    .clear(state == R_IDLE),
    .run  (state != R_IDLE),
    .tick (tick)
  );

  assign dsr = !dato_valid;

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state       <= R_IDLE;
      shift       <= '0;
      idx         <= '0;
      dato        <= '0;
      dato_valid  <= 1'b0;
      frame_error <= 1'b0;
    end else begin
      state       <= state_n;
      shift       <= shift_n;
      idx         <= idx_n;
      dato        <= dato_n;
      dato_valid  <= valid_n;
      frame_error <= ferr_n;
    end
  end

`ifdef RX_OVERRUN_EN
  always_ff @(posedge clock or posedge reset) begin
    if (reset) overrun <= 1'b0;
    else       overrun <= ovr_n;
  end
`endif

  always_comb begin
    state_n = state;
    shift_n = shift;
    idx_n   = idx;
    dato_n  = dato;
    valid_n = dato_valid;
    ferr_n  = 1'b0;
`ifdef RX_OVERRUN_EN
    ovr_n   = 1'b0;
`endif
    if (dato_valid && dato_ack) valid_n = 1'b0;
    unique case (state)
      R_IDLE: begin
        if (serial_in == START_LEVEL) begin
          idx_n   = '0;
          state_n = R_DATA;
        end
      end
      R_DATA: begin
        if (tick) begin
          shift_n = {shift[DATA_BITS-2:0], serial_in};
          idx_n   = idx + 1'b1;
          if (idx == LAST_BIT) state_n = R_STOP;
        end
      end
      R_STOP: begin
        if (tick) begin
          state_n = R_IDLE;
          if (serial_in == STOP_LEVEL) begin
            // a completing frame wins over a same-edge ack
            if (!dato_valid || dato_ack) begin
              dato_n  = shift;
              valid_n = 1'b1;
            end else begin
`ifdef RX_OVERRUN_EN
              ovr_n  = 1'b1;
`else
              dato_n = shift;
`endif
            end
          end else begin
            ferr_n = 1'b1;
          end
        end
      end
      default: state_n = R_IDLE;
    endcase
  end

endmodule
